fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 134 +++++++++++++
 tb/tb_fb_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer single-port RAM arbiter: display burst fetches have absolute
// priority over single-word draw writes.
module fb_arbiter #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              disp_start_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic              disp_done_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              overrun_o
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                overrun_q, overrun_d;
  logic                rd_vld_q, rd_last_q;
  logic [DATA_W-1:0]   disp_data_q;
  logic                disp_valid_q, disp_done_q;
  logic                wr_accept, rd_issue, rd_last;

  // Write grant is combinational so a display request stalls a write in the same cycle.
  always_comb begin
    wr_ready_o = !reset_i && (((state_q == IDLE) && !disp_start_i) || (state_q == DRAIN));
    wr_accept  = wr_valid_i && wr_ready_o;
    rd_issue   = (state_q == FETCH);
    rd_last    = rd_issue && (cnt_q == CNT_W'(BURST_LEN));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    overrun_d   = overrun_q;
    if (wr_accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_addr_i;
      mem_wdata_d = wr_data_i;
    end
    case (state_q)
      IDLE: begin
        if (disp_start_i) begin
          state_d    = FETCH;
          mem_addr_d = disp_base_i;
          cnt_d      = CNT_W'(1);
        end
      end
      FETCH: begin
        if (disp_start_i) overrun_d = 1'b1;
        if (rd_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = 1'b0;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (disp_start_i) overrun_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle after the address, then is registered once more.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      overrun_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      overrun_q    <= overrun_d;
      rd_vld_q     <= rd_issue;
      rd_last_q    <= rd_last;
      disp_valid_q <= rd_vld_q;
      disp_done_q  <= rd_last_q;
      if (rd_vld_q) disp_data_q <= mem_rdata_i;
    end
  end

  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;
  assign disp_done_o  = disp_done_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a 16-word and a 4-word instance, each with a
// RAM model returning addr[11:0] one cycle after the address.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ds16, ds4;
  logic [16:0] base16, base4;
  logic        wv;
  logic [16:0] wa;
  logic [11:0] wd;

  logic [11:0] data16, data4, wdat16, wdat4, rdata16, rdata4;
  logic        vld16, vld4, done16, done4, rdy16, rdy4, we16, we4, ovr16, ovr4;
  logic [16:0] addr16, addr4;

  int nerr = 0;
  int nchk = 0;
  int nvld, ndone;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rdata16 <= addr16[11:0];
    rdata4  <= addr4[11:0];
  end

  fb_arbiter #(.ADDR_W(17), .DATA_W(12), .BURST_LEN(16)) u_dut16 (
    .clk_i(clk), .reset_i(rst), .disp_start_i(ds16), .disp_base_i(base16),
    .disp_data_o(data16), .disp_valid_o(vld16), .disp_done_o(done16),
    .wr_valid_i(wv), .wr_addr_i(wa), .wr_data_i(wd), .wr_ready_o(rdy16),
    .mem_addr_o(addr16), .mem_we_o(we16), .mem_wdata_o(wdat16),
    .mem_rdata_i(rdata16), .overrun_o(ovr16));

  fb_arbiter #(.ADDR_W(17), .DATA_W(12), .BURST_LEN(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .disp_start_i(ds4), .disp_base_i(base4),
    .disp_data_o(data4), .disp_valid_o(vld4), .disp_done_o(done4),
    .wr_valid_i(1'b0), .wr_addr_i(17'h0), .wr_data_i(12'h0), .wr_ready_o(rdy4),
    .mem_addr_o(addr4), .mem_we_o(we4), .mem_wdata_o(wdat4),
    .mem_rdata_i(rdata4), .overrun_o(ovr4));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ds16 = 1'b0; ds4 = 1'b0; base16 = '0; base4 = '0;
    wv = 1'b0; wa = '0; wd = '0;

    // Reset held two cycles
    adv(); adv(); smp();
    check("rst_valid", 32'(vld16), 32'h0);
    check("rst_done", 32'(done16), 32'h0);
    check("rst_data", 32'(data16), 32'h0);
    check("rst_addr", 32'(addr16), 32'h0);
    check("rst_we", 32'(we16), 32'h0);
    check("rst_wdata", 32'(wdat16), 32'h0);
    check("rst_ovr", 32'(ovr16), 32'h0);
    check("rst_rdy", 32'(rdy16), 32'h0);
    adv(); rst = 1'b0; smp();
    check("post_rst_rdy", 32'(rdy16), 32'h1);
    check("post_rst_we", 32'(we16), 32'h0);
    check("post_rst_rdy4", 32'(rdy4), 32'h1);

    // Back-to-back writes, then idle
    adv(); wv = 1'b1; wa = 17'h00055; wd = 12'h123; smp();
    check("wr1_rdy", 32'(rdy16), 32'h1);
    adv(); wa = 17'h00056; wd = 12'h456; smp();
    check("wr1_we", 32'(we16), 32'h1);
    check("wr1_addr", 32'(addr16), 32'h00055);
    check("wr1_data", 32'(wdat16), 32'h123);
    adv(); wv = 1'b0; smp();
    check("wr2_we", 32'(we16), 32'h1);
    check("wr2_addr", 32'(addr16), 32'h00056);
    check("wr2_data", 32'(wdat16), 32'h456);
    adv(); smp();
    check("idle_we", 32'(we16), 32'h0);
    check("idle_addr_hold", 32'(addr16), 32'h00056);

    // 16-word burst at 0x00100 with a write held pending from T
    for (int c = 0; c <= 22; c++) begin
      adv();
      ds16 = (c == 0); base16 = (c == 0) ? 17'h00100 : 17'h1ABCD;
      if (c == 0) begin wv = 1'b1; wa = 17'h00200; wd = 12'hABC; end
      if (c == 18) wv = 1'b0;
      smp();
      check($sformatf("b16_valid_c%0d", c), 32'(vld16), 32'((c >= 3 && c <= 18) ? 1 : 0));
      check($sformatf("b16_done_c%0d", c), 32'(done16), 32'((c == 18) ? 1 : 0));
      if (c >= 3 && c <= 18)
        check($sformatf("b16_data_c%0d", c), 32'(data16), 32'(12'h100 + 12'(c - 3)));
      if (c >= 1 && c <= 16) begin
        check($sformatf("b16_addr_c%0d", c), 32'(addr16), 32'(17'h00100 + 17'(c - 1)));
      end
      if (c <= 16) check($sformatf("b16_rdy_c%0d", c), 32'(rdy16), 32'h0);
      if (c == 17) check("b16_rdy_c17", 32'(rdy16), 32'h1);
      check($sformatf("b16_we_c%0d", c), 32'(we16), 32'((c == 18) ? 1 : 0));
      if (c == 18) begin
        check("b16_wr_addr", 32'(addr16), 32'h00200);
        check("b16_wr_data", 32'(wdat16), 32'hABC);
      end
    end
    check("b16_no_ovr", 32'(ovr16), 32'h0);

    // 4-word burst wrapping the address space
    for (int c = 0; c <= 9; c++) begin
      adv();
      ds4 = (c == 0); base4 = 17'h1FFFE;
      smp();
      case (c)
        1: check("b4_addr_c1", 32'(addr4), 32'h1FFFE);
        2: check("b4_addr_c2", 32'(addr4), 32'h1FFFF);
        3: check("b4_addr_c3", 32'(addr4), 32'h00000);
        4: check("b4_addr_c4", 32'(addr4), 32'h00001);
        default: ;
      endcase
      check($sformatf("b4_valid_c%0d", c), 32'(vld4), 32'((c >= 3 && c <= 6) ? 1 : 0));
      check($sformatf("b4_done_c%0d", c), 32'(done4), 32'((c == 6) ? 1 : 0));
      if (c == 3) check("b4_data_c3", 32'(data4), 32'hFFE);
      if (c == 5) check("b4_data_c5", 32'(data4), 32'h000);
      if (c == 6) check("b4_data_c6", 32'(data4), 32'h001);
      if (c == 5) check("b4_rdy_drain", 32'(rdy4), 32'h1);
    end

    // Second start during FETCH is dropped and flags overrun
    nvld = 0; ndone = 0;
    for (int c = 0; c <= 30; c++) begin
      adv();
      ds16 = (c == 0 || c == 5); base16 = 17'h00300;
      smp();
      if (vld16) nvld++;
      if (done16) ndone++;
      if (c == 5) check("ovr_c5", 32'(ovr16), 32'h0);
      if (c == 6) check("ovr_c6", 32'(ovr16), 32'h1);
      if (c == 30) check("ovr_c30", 32'(ovr16), 32'h1);
      if (c == 3) check("ovr_first_data", 32'(data16), 32'h300);
    end
    check("ovr_nvalid", 32'(nvld), 32'd16);
    check("ovr_ndone", 32'(ndone), 32'd1);

    // Reset sampled at the edge ending T+6 aborts the burst
    nvld = 0; ndone = 0;
    for (int c = 0; c <= 25; c++) begin
      adv();
      ds16 = (c == 0); base16 = 17'h00400;
      rst = (c == 6);
      smp();
      if (c >= 7 && vld16) nvld++;
      if (done16) ndone++;
      if (c == 6) check("abort_valid_c6", 32'(vld16), 32'h1);
      if (c == 7) begin
        check("abort_rdy_c7", 32'(rdy16), 32'h1);
        check("abort_ovr_c7", 32'(ovr16), 32'h0);
        check("abort_addr_c7", 32'(addr16), 32'h0);
      end
    end
    check("abort_nvalid", 32'(nvld), 32'd0);
    check("abort_ndone", 32'(ndone), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
